// File: rtl/kd_root_responder.sv
// Root-node responder for a k-d tree builder: stores up to NUM_CENTERS centers, sorts them
// on a chosen axis with odd-even transposition, then streams them out. Option: KD_RESP_PARTIAL_SORT_EN.
module kd_root_responder #(
    parameter int COMMAND_SIZE = 5,
    parameter int DATA_SIZE    = 24,
    parameter int NUM_CENTERS  = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [COMMAND_SIZE-1:0] command_from_top,
    input  logic [DATA_SIZE-1:0]    data_from_top,
    output logic [COMMAND_SIZE-1:0] command_to_top,
    output logic [DATA_SIZE-1:0]    data_to_top
);
    localparam int CW = $clog2(NUM_CENTERS + 1);

    localparam logic [COMMAND_SIZE-1:0] CMD_NOP        = COMMAND_SIZE'('h00);
    localparam logic [COMMAND_SIZE-1:0] CMD_FILL       = COMMAND_SIZE'('h01);
    localparam logic [COMMAND_SIZE-1:0] CMD_CFG_AXIS   = COMMAND_SIZE'('h02);
    localparam logic [COMMAND_SIZE-1:0] CMD_CFG_DONE   = COMMAND_SIZE'('h07);
    localparam logic [COMMAND_SIZE-1:0] CMD_FILL_DONE  = COMMAND_SIZE'('h05);
    localparam logic [COMMAND_SIZE-1:0] CMD_BUSY       = COMMAND_SIZE'('h08);
    localparam logic [COMMAND_SIZE-1:0] CMD_DNE        = COMMAND_SIZE'('h10);
    localparam logic [COMMAND_SIZE-1:0] CMD_VALID_SORT = COMMAND_SIZE'('h0f);
    localparam logic [COMMAND_SIZE-1:0] CMD_VALID_DONE = COMMAND_SIZE'('h11);
    localparam logic [COMMAND_SIZE-1:0] CMD_EXPOSE     = COMMAND_SIZE'('h12);
    localparam logic [COMMAND_SIZE-1:0] CMD_START      = COMMAND_SIZE'('h14);
    localparam logic [COMMAND_SIZE-1:0] CMD_SORT_DONE  = COMMAND_SIZE'('h15);
    localparam logic [COMMAND_SIZE-1:0] CMD_RST_DONE   = COMMAND_SIZE'('h1e);
    localparam logic [COMMAND_SIZE-1:0] CMD_RST        = COMMAND_SIZE'('h1f);

    typedef enum logic [2:0] {
        S_UNINIT,
        S_READY,
        S_FILL,
        S_FILLED,
        S_SORT,
        S_SORTED
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_count, w_count_nxt;
    logic [CW-1:0]           r_ptr, w_ptr_nxt;
    logic [CW-1:0]           r_phase, w_phase_nxt;
    logic [1:0]              r_axis, w_axis_nxt;
    logic [COMMAND_SIZE-1:0] r_cmd, w_cmd_nxt;
    logic [DATA_SIZE-1:0]    r_dout, w_dout_nxt;
    logic [DATA_SIZE-1:0]    r_slot     [NUM_CENTERS];
    logic [DATA_SIZE-1:0]    w_slot_nxt [NUM_CENTERS];
    logic [DATA_SIZE-1:0]    w_swapped  [NUM_CENTERS];
    logic                    w_can_start;

    function automatic logic [7:0] f_key(input logic [DATA_SIZE-1:0] d, input logic [1:0] ax);
        case (ax)
            2'd1:    f_key = d[15:8];
            2'd2:    f_key = d[7:0];
            default: f_key = d[23:16];
        endcase
    endfunction

`ifdef KD_RESP_PARTIAL_SORT_EN
    // FILL always holds at least one entry, so a partial sort is always well-formed.
    assign w_can_start = (r_state == S_FILLED) || (r_state == S_FILL);
`else
    assign w_can_start = (r_state == S_FILLED);
`endif

    // One transposition phase: even phases pair (0,1),(2,3)..., odd phases (1,2),(3,4)...
    // Strict compare keeps equal keys in place, making the sort stable.
    always_comb begin
        for (int i = 0; i < NUM_CENTERS; i++) begin
            w_swapped[i] = r_slot[i];
        end
        for (int i = 0; i < NUM_CENTERS - 1; i++) begin
            if ((i[0] == r_phase[0]) && (CW'(i + 1) < r_count) &&
                (f_key(r_slot[i], r_axis) > f_key(r_slot[i+1], r_axis))) begin
                w_swapped[i]   = r_slot[i+1];
                w_swapped[i+1] = r_slot[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_ptr_nxt   = r_ptr;
        w_phase_nxt = r_phase;
        w_axis_nxt  = r_axis;
        w_cmd_nxt   = r_cmd;
        w_dout_nxt  = r_dout;
        for (int i = 0; i < NUM_CENTERS; i++) begin
            w_slot_nxt[i] = r_slot[i];
        end

        if (command_from_top == CMD_RST) begin
            w_state_nxt = S_READY;
            w_count_nxt = '0;
            w_ptr_nxt   = '0;
            w_phase_nxt = '0;
            w_axis_nxt  = 2'd0;
            w_cmd_nxt   = CMD_RST_DONE;
        end else begin
            case (r_state)
                S_UNINIT: ;
                S_SORT: begin
                    for (int i = 0; i < NUM_CENTERS; i++) begin
                        w_slot_nxt[i] = w_swapped[i];
                    end
                    w_phase_nxt = r_phase + CW'(1);
                    w_cmd_nxt   = CMD_BUSY;
                    if (r_phase == r_count - CW'(1)) begin
                        w_state_nxt = S_SORTED;
                        w_ptr_nxt   = '0;
                        w_cmd_nxt   = CMD_SORT_DONE;
                    end
                end
                default: begin
                    case (command_from_top)
                        CMD_NOP: ;
                        CMD_FILL: begin
                            if (r_state == S_READY || r_state == S_FILL) begin
                                w_slot_nxt[r_count] = data_from_top;
                                w_count_nxt         = r_count + CW'(1);
                                if (r_count + CW'(1) == CW'(NUM_CENTERS)) begin
                                    w_state_nxt = S_FILLED;
                                    w_cmd_nxt   = CMD_FILL_DONE;
                                end else begin
                                    w_state_nxt = S_FILL;
                                    w_cmd_nxt   = CMD_BUSY;
                                end
                            end else if (r_state == S_SORTED) begin
                                w_cmd_nxt = CMD_DNE;
                            end
                        end
                        CMD_CFG_AXIS: begin
                            if (r_state != S_SORTED) begin
                                if (data_from_top[1:0] != 2'd3) begin
                                    w_axis_nxt = data_from_top[1:0];
                                end
                                w_cmd_nxt = CMD_CFG_DONE;
                            end else begin
                                w_cmd_nxt = CMD_DNE;
                            end
                        end
                        CMD_START: begin
                            if (w_can_start) begin
                                w_state_nxt = S_SORT;
                                w_phase_nxt = '0;
                                w_cmd_nxt   = CMD_BUSY;
                            end else begin
                                w_cmd_nxt = CMD_DNE;
                            end
                        end
                        CMD_EXPOSE: begin
                            if (r_state == S_SORTED) begin
                                w_dout_nxt = r_slot[r_ptr];
                                if (r_ptr == r_count - CW'(1)) begin
                                    w_cmd_nxt = CMD_VALID_DONE;
                                    w_ptr_nxt = '0;
                                end else begin
                                    w_cmd_nxt = CMD_VALID_SORT;
                                    w_ptr_nxt = r_ptr + CW'(1);
                                end
                            end else begin
                                w_cmd_nxt = CMD_DNE;
                            end
                        end
                        default: w_cmd_nxt = CMD_DNE;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_UNINIT;
            r_count <= '0;
            r_ptr   <= '0;
            r_phase <= '0;
            r_axis  <= 2'd0;
            r_cmd   <= CMD_NOP;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_ptr   <= w_ptr_nxt;
            r_phase <= w_phase_nxt;
            r_axis  <= w_axis_nxt;
            r_cmd   <= w_cmd_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // Center storage carries no reset; its contents are meaningless until filled.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CENTERS; i++) begin
            r_slot[i] <= w_slot_nxt[i];
        end
    end

    assign command_to_top = r_cmd;
    assign data_to_top    = r_dout;

endmodule
